// File: rtl/md_pkg.sv
// md_pkg: op encodings, FSM states, default latencies and decode helpers for md_sched.
// Optional build macro MDU_MADD_EN adds the MADD/MADDU accumulate ops.
// With MDU_MADD_EN the op field grows to 4 bits so the two new codes fit.
package md_pkg;

    localparam int unsigned MD_XLEN            = 32;
    localparam int unsigned MD_MULT_CYCLES_DEF = 5;
    localparam int unsigned MD_DIV_CYCLES_DEF  = 10;
    localparam int unsigned MD_CNT_W_DEF       = 4;

`ifdef MDU_MADD_EN
    localparam int unsigned MD_OP_W = 4;
`else
    localparam int unsigned MD_OP_W = 3;
`endif

    // Code 7 (and any code not listed here) decodes as NONE.
    typedef enum logic [MD_OP_W-1:0] {
        MD_NONE  = MD_OP_W'(0),
        MD_MULT  = MD_OP_W'(1),
        MD_MULTU = MD_OP_W'(2),
        MD_DIV   = MD_OP_W'(3),
        MD_DIVU  = MD_OP_W'(4),
        MD_MTHI  = MD_OP_W'(5),
        MD_MTLO  = MD_OP_W'(6)
`ifdef MDU_MADD_EN
        ,
        MD_MADD  = MD_OP_W'(8),
        MD_MADDU = MD_OP_W'(9)
`endif
    } md_op_e;

    typedef enum logic {
        MD_ST_IDLE = 1'b0,
        MD_ST_RUN  = 1'b1
    } md_state_e;

    // Ops that open a busy window.
    function automatic logic md_is_launch(input md_op_e op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: md_is_launch = 1'b1;
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU:                  md_is_launch = 1'b1;
`endif
            default:                            md_is_launch = 1'b0;
        endcase
    endfunction

    // Ops that take the divide latency.
    function automatic logic md_is_div(input md_op_e op);
        md_is_div = (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_if.sv
// md_if: E-stage md op bus, D-stage stall and HI/LO read path for md_sched.
interface md_if;
    import md_pkg::*;

    md_op_e              e_op;
    logic                e_valid;
    logic [MD_XLEN-1:0]  e_rs;
    logic [MD_XLEN-1:0]  e_rt;
    logic                d_is_md;
    logic                start;
    logic                busy;
    logic                stall_md;
    logic [MD_XLEN-1:0]  hi;
    logic [MD_XLEN-1:0]  lo;

    // Pipeline side: issues ops, consumes stall and HI/LO.
    modport master (
        output e_op, e_valid, e_rs, e_rt, d_is_md,
        input  start, busy, stall_md, hi, lo
    );

    // Scheduler side.
    modport slave (
        input  e_op, e_valid, e_rs, e_rt, d_is_md,
        output start, busy, stall_md, hi, lo
    );
endinterface

// File: rtl/md_arith.sv
// md_arith: combinational 64-bit {hi,lo} result from the latched op and operands.
// Builds the MADD/MADDU accumulator only when MDU_MADD_EN is defined.
module md_arith
    import md_pkg::*;
(
    input  md_op_e              op_i,
    input  logic [MD_XLEN-1:0]  rs_i,
    input  logic [MD_XLEN-1:0]  rt_i,
    input  logic [MD_XLEN-1:0]  hi_i,
    input  logic [MD_XLEN-1:0]  lo_i,
    output logic [2*MD_XLEN-1:0] res_c_o
);

    localparam int unsigned W  = MD_XLEN;
    localparam int unsigned W2 = 2 * MD_XLEN;

    logic          mul_signed;
    logic [W2-1:0] mul_a;
    logic [W2-1:0] mul_b;
    logic [W2-1:0] prod;
    logic          div_signed;
    logic          a_neg;
    logic          b_neg;
    logic          div_zero;
    logic [W-1:0]  a_mag;
    logic [W-1:0]  b_mag;
    logic [W-1:0]  b_safe;
    logic [W-1:0]  q_mag;
    logic [W-1:0]  r_mag;
    logic [W-1:0]  quo;
    logic [W-1:0]  rem;

    // One shared multiplier: sign- or zero-extend to 64 bits, keep the low 64 product bits.
    always_comb begin
        mul_signed = (op_i == MD_MULT);
`ifdef MDU_MADD_EN
        mul_signed = mul_signed || (op_i == MD_MADD);
`endif
        mul_a = {{W{mul_signed & rs_i[W-1]}}, rs_i};
        mul_b = {{W{mul_signed & rt_i[W-1]}}, rt_i};
        prod  = mul_a * mul_b;
    end

    // One shared unsigned divider on magnitudes; signs restored afterwards.
    // 0x80000000 / -1 falls out naturally: magnitude 0x80000000 negates to itself.
    always_comb begin
        div_signed = (op_i == MD_DIV);
        a_neg      = div_signed & rs_i[W-1];
        b_neg      = div_signed & rt_i[W-1];
        a_mag      = a_neg ? (~rs_i + W'(1)) : rs_i;
        b_mag      = b_neg ? (~rt_i + W'(1)) : rt_i;
        div_zero   = (rt_i == '0);
        b_safe     = div_zero ? W'(1) : b_mag;
        q_mag      = a_mag / b_safe;
        r_mag      = a_mag % b_safe;
        quo        = (a_neg ^ b_neg) ? (~q_mag + W'(1)) : q_mag;
        rem        = a_neg ? (~r_mag + W'(1)) : r_mag;
    end

    // Result select; divide by zero hands back the current HI/LO so the commit is a no-op.
    always_comb begin
        res_c_o = {hi_i, lo_i};
        case (op_i)
            MD_MULT, MD_MULTU: res_c_o = prod;
            MD_DIV, MD_DIVU:   res_c_o = div_zero ? {hi_i, lo_i} : {rem, quo};
`ifdef MDU_MADD_EN
            MD_MADD, MD_MADDU: res_c_o = {hi_i, lo_i} + prod;
`endif
            default:           res_c_o = {hi_i, lo_i};
        endcase
    end

endmodule

// File: rtl/md_sched.sv
// md_sched: multiply/divide scheduler and HI/LO owner beside the E-stage ALU.
// Launches one md op into a fixed busy window, commits HI/LO at window end,
// and stalls D-stage md instructions while an op is starting or in flight.
// Optional build macro MDU_MADD_EN enables MADD/MADDU (accumulate at commit).
// MULT_CYCLES and DIV_CYCLES must be >= 1 and fit in CNT_W bits.
module md_sched
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = MD_DIV_CYCLES_DEF,
    parameter int unsigned CNT_W       = MD_CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  md
);

    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    md_op_e              op_q,    op_d;
    logic [MD_XLEN-1:0]  rs_q,    rs_d;
    logic [MD_XLEN-1:0]  rt_q,    rt_d;
    logic [MD_XLEN-1:0]  hi_q,    hi_d;
    logic [MD_XLEN-1:0]  lo_q,    lo_d;
    logic [2*MD_XLEN-1:0] res_c;
    logic                start_c;
    logic                busy;

    md_arith u_arith (
        .op_i    (op_q),
        .rs_i    (rs_q),
        .rt_i    (rt_q),
        .hi_i    (hi_q),
        .lo_i    (lo_q),
        .res_c_o (res_c)
    );

    // State, counter, latched op and HI/LO registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= MD_ST_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            rs_q    <= '0;
            rt_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Next state: launch or MTHI/MTLO when idle, count down and commit when running.
    // Ops arriving while running are dropped; stall_md keeps legal code from doing that.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        start_c = 1'b0;
        case (state_q)
            MD_ST_IDLE: begin
                if (md.e_valid) begin
                    if (md_is_launch(md.e_op)) begin
                        start_c = 1'b1;
                        state_d = MD_ST_RUN;
                        op_d    = md.e_op;
                        rs_d    = md.e_rs;
                        rt_d    = md.e_rt;
                        cnt_d   = md_is_div(md.e_op) ? CNT_W'(DIV_CYCLES)
                                                     : CNT_W'(MULT_CYCLES);
                    end else if (md.e_op == MD_MTHI) begin
                        hi_d = md.e_rs;
                    end else if (md.e_op == MD_MTLO) begin
                        lo_d = md.e_rs;
                    end
                end
            end
            MD_ST_RUN: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = MD_ST_IDLE;
                    {hi_d, lo_d} = res_c;
                end
            end
            default: state_d = MD_ST_IDLE;
        endcase
    end

    // Interface outputs: busy and HI/LO straight from flops, start/stall combinational.
    assign busy        = (state_q == MD_ST_RUN);
    assign md.busy     = busy;
    assign md.start    = start_c;
    assign md.stall_md = md.d_is_md & (start_c | busy);
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

endmodule
